// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank sequencer: op codes, FSM states and
// the JK next-state rule used by both the shadow register and the bench.
package jk_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } jk_state_e;

  function automatic logic jk_next_bit(input logic q, input logic j, input logic k);
    logic q_n;
    case ({j, k})
      2'b00:   q_n = q;
      2'b01:   q_n = 1'b0;
      2'b10:   q_n = 1'b1;
      default: q_n = ~q;
    endcase
    return q_n;
  endfunction

endpackage

// File: rtl/jk_cmd_decode.sv
// Combinational J/K decode from a latched op and mask; outputs are quiet
// unless en is asserted.
module jk_cmd_decode
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_mask,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);

  // op[1] drives J (SET, TOG), op[0] drives K (CLR, TOG)
  assign o_j = i_mask & {WIDTH{i_en & i_op[1]}};
  assign o_k = i_mask & {WIDTH{i_en & i_op[0]}};

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven J/K pulse sequencer for an external JK flip-flop bank,
// with a shadow copy of the bank's Q vector.
//
// state | meaning
// IDLE  | ready for a command, j=k=0
// APPLY | drive decoded j/k for one cycle, shadow follows the bank
// GAP   | one quiet cycle between successive applications
// DONE  | one-cycle done pulse, then back to IDLE
module jk_bank_sequencer
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_shadow,
  output logic             busy,
  output logic             done
);

  jk_state_e        r_state;
  jk_state_e        w_state_nxt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_accept;
  logic             w_apply;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_apply  = (r_state == ST_APPLY);

  jk_cmd_decode #(
    .WIDTH(WIDTH)
  ) u_decode (
    .i_op  (r_op),
    .i_mask(r_mask),
    .i_en  (w_apply),
    .o_j   (w_j),
    .o_k   (w_k)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (cmd_valid) w_state_nxt = ST_APPLY;
      ST_APPLY: w_state_nxt = (r_rem == '0) ? ST_DONE : ST_GAP;
      ST_GAP:   w_state_nxt = ST_APPLY;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_mask  <= '0;
      r_rem   <= '0;
      r_q     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_mask <= cmd_mask;
        r_rem  <= cmd_rep;
      end
      if (w_apply) begin
        // shadow tracks the bank on the same edge the bank samples j/k
        for (int i = 0; i < WIDTH; i++) begin
          r_q[i] <= jk_next_bit(r_q[i], w_j[i], w_k[i]);
        end
        if (r_rem != '0) r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign j         = w_j;
  assign k         = w_k;
  assign q_shadow  = r_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed self-checking bench for jk_bank_sequencer with a behavioural JK bank.
module tb_jk_bank_sequencer;
  import jk_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_rep;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_shadow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] bank_q;

  int checks = 0;
  int errors = 0;

  jk_bank_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_mask (cmd_mask),
    .cmd_rep  (cmd_rep),
    .j        (j),
    .k        (k),
    .q_shadow (q_shadow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset) bank_q <= '0;
    else for (int i = 0; i < WIDTH; i++) bank_q[i] <= jk_next_bit(bank_q[i], j[i], k[i]);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [WIDTH-1:0] mask, input logic [CNT_W-1:0] rep);
    cmd_op = op; cmd_mask = mask; cmd_rep = rep; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || j !== 8'h00 || k !== 8'h00 || q_shadow !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b j=%h k=%h q=%h busy=%b done=%b, required 1 00 00 00 0 0",
               cmd_ready, j, k, q_shadow, busy, done);
    end
  endtask

  task automatic test_set;
    accept(OP_SET, 8'hF0, 4'd0);
    checks++;
    if (j !== 8'hF0 || k !== 8'h00 || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL set_apply: j=%h k=%h busy=%b ready=%b done=%b, required F0 00 1 0 0", j, k, busy, cmd_ready, done);
    end
    tick();
    checks++;
    if (q_shadow !== 8'hF0 || done !== 1'b1 || j !== 8'h00 || k !== 8'h00) begin
      errors++;
      $display("FAIL set_done: q=%h done=%b j=%h k=%h, required F0 1 00 00", q_shadow, done, j, k);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL set_idle: done=%b ready=%b busy=%b, required 0 1 0", done, cmd_ready, busy);
    end
  endtask

  task automatic test_toggle;
    logic [WIDTH-1:0] exp_j [6] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [WIDTH-1:0] exp_q [6] = '{8'hF0, 8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'h0F};
    logic             exp_d [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    accept(OP_TOG, 8'hFF, 4'd2);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (j !== exp_j[c] || k !== exp_j[c] || q_shadow !== exp_q[c] || done !== exp_d[c]) begin
        errors++;
        $display("FAIL tog_seq[%0d]: j=%h k=%h q=%h done=%b, required %h %h %h %b",
                 c, j, k, q_shadow, done, exp_j[c], exp_j[c], exp_q[c], exp_d[c]);
      end
      if (c < 5) tick();
    end
    checks++;
    if (bank_q !== 8'h0F) begin
      errors++;
      $display("FAIL tog_bank: bank_q=%h, required 0F", bank_q);
    end
    tick();
  endtask

  task automatic test_clear;
    int n;
    accept(OP_SET, 8'hF0, 4'd0);
    tick(); tick();
    checks++;
    if (q_shadow !== 8'hFF) begin
      errors++;
      $display("FAIL clr_pre: q=%h, required FF", q_shadow);
    end
    accept(OP_CLR, 8'h0C, 4'd0);
    checks++;
    if (j !== 8'h00 || k !== 8'h0C) begin
      errors++;
      $display("FAIL clr_apply: j=%h k=%h, required 00 0C", j, k);
    end
    n = 0;
    while (busy && n < 40) begin n++; tick(); end
    checks++;
    if (n !== 2 || q_shadow !== 8'hF3 || bank_q !== 8'hF3) begin
      errors++;
      $display("FAIL clr_result: busy_cycles=%0d q=%h bank=%h, required 2 F3 F3", n, q_shadow, bank_q);
    end
  endtask

  task automatic test_zero_mask;
    int n;
    logic seen_done;
    accept(OP_SET, 8'h00, 4'd1);
    n = 0; seen_done = 1'b0;
    while (busy && n < 40) begin
      if (done) seen_done = 1'b1;
      n++; tick();
    end
    checks++;
    if (n !== 4 || seen_done !== 1'b1 || q_shadow !== 8'hF3) begin
      errors++;
      $display("FAIL zero_mask: busy_cycles=%0d done_seen=%b q=%h, required 4 1 F3", n, seen_done, q_shadow);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int bad;
    cmd_op = OP_HOLD; cmd_mask = 8'hFF; cmd_rep = 4'd3; cmd_valid = 1'b1;
    tick();
    cmd_op = OP_SET; cmd_mask = 8'h01; cmd_rep = 4'd0;
    n = 0; bad = 0;
    while (busy && n < 40) begin
      if (cmd_ready !== 1'b0 || q_shadow !== 8'hF3 || j !== 8'h00 || k !== 8'h00) bad++;
      n++; tick();
    end
    checks++;
    if (n !== 8 || bad !== 0) begin
      errors++;
      $display("FAIL hold_busy: busy_cycles=%0d bad_cycles=%0d, required 8 0", n, bad);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_ready: ready=%b, required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || j !== 8'h01 || k !== 8'h00) begin
      errors++;
      $display("FAIL b2b_second: busy=%b j=%h k=%h, required 1 01 00", busy, j, k);
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || q_shadow !== 8'hF3) begin
      errors++;
      $display("FAIL b2b_end: busy=%b q=%h, required 0 F3", busy, q_shadow);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    accept(OP_TOG, 8'hFF, 4'd5);
    tick(); tick();
    checks++;
    if (j !== 8'hFF || q_shadow !== 8'h0C) begin
      errors++;
      $display("FAIL rst_mid_pre: j=%h q=%h, required FF 0C", j, q_shadow);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (j !== 8'h00 || k !== 8'h00 || q_shadow !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || bank_q !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_after: j=%h k=%h q=%h busy=%b done=%b ready=%b bank=%h, required 00 00 00 0 0 1 00",
               j, k, q_shadow, busy, done, cmd_ready, bank_q);
    end
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL rst_mid_nodone: active_cycles=%0d, required 0", dones);
    end
  endtask

  task automatic test_reset_accept;
    cmd_op = OP_SET; cmd_mask = 8'hFF; cmd_rep = 4'd0; cmd_valid = 1'b1; reset = 1'b1;
    tick();
    cmd_valid = 1'b0; reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || q_shadow !== 8'h00) begin
      errors++;
      $display("FAIL rst_accept: busy=%b ready=%b q=%h, required 0 1 00", busy, cmd_ready, q_shadow);
    end
  endtask

  task automatic test_max_rep;
    int n_busy;
    int n_apply;
    int n_done;
    accept(OP_TOG, 8'h01, 4'd15);
    n_busy = 0; n_apply = 0; n_done = 0;
    while (busy && n_busy < 100) begin
      if (j === 8'h01 && k === 8'h01) n_apply++;
      if (done) n_done++;
      n_busy++; tick();
    end
    checks++;
    if (n_apply !== 16 || n_busy !== 32 || n_done !== 1) begin
      errors++;
      $display("FAIL max_rep_count: applies=%0d busy=%0d dones=%0d, required 16 32 1", n_apply, n_busy, n_done);
    end
    checks++;
    if (q_shadow !== 8'h00 || bank_q !== 8'h00) begin
      errors++;
      $display("FAIL max_rep_q: q=%h bank=%h, required 00 00", q_shadow, bank_q);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mask = '0; cmd_rep = '0;
    test_reset();
    test_set();
    test_toggle();
    test_clear();
    test_zero_mask();
    test_back_to_back();
    test_reset_mid();
    test_reset_accept();
    test_max_rep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
